sram_burst_counter: RTL and testbench
=====================================

Name: sram_burst_counter

Overview:
Multi-channel, parametrised SRAM address counter for the RAID5 stripe datapath. It generalises the fixed 7-bit, single-channel SRAM counter into NUM_CH independent wrap counters. Each counter has a programmable wrap point. A burst FSM steps one selected channel for a requested number of beats. Per-channel pointers persist between bursts, so each disk/parity buffer resumes where it left off.

Parameters:
CNT_W, 7, width of each channel counter / SRAM address
NUM_CH, 4, number of independent channel counters (>=2)
CH_W, $clog2(NUM_CH), derived channel-select width (localparam, not overridable)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous clear: zero all channel counters, abort burst
start  input  1  request burst; sampled only in IDLE
ch_sel  input  CH_W  channel to step; latched on accepted start
wrap_val  input  CNT_W  wrap point; latched on start; 0 = full 2^CNT_W range
burst_len  input  CNT_W  beats in burst; latched on start
cnt_enable  input  1  beat qualifier in RUN; low = stall, count held
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse in DONE
rollover_flag  output  1  high in a beat cycle where the active channel wraps
count_out  output  CNT_W  current address of the active channel
active_ch  output  CH_W  latched channel index
ch_count  output  NUM_CH*CNT_W  all channel counters, flat; channel i at [i*CNT_W +: CNT_W]

Behaviour:
- Reset (rst high, async): all channel counters 0, FSM IDLE, beats_left 0, latched regs 0. Outputs: busy 0, done 0, rollover_flag 0, count_out 0, active_ch 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN: start=1 and burst_len!=0. Latch ch_sel, wrap_val and burst_len into beats_left.
  - IDLE -> DONE: start=1 and burst_len==0. No beats are taken.
  - RUN -> DONE: a beat is taken while beats_left==1.
  - DONE -> IDLE: unconditionally, after one cycle.
- Latency: start accepted at edge N; busy=1 and count_out=first address in cycle N+1.
- Beat: in RUN with cnt_enable=1, the active channel advances at the next edge and beats_left decrements. With cnt_enable=0, nothing changes.
- Wrap: the step is count==W-1 ? 0 : count+1, where W=wrap_val, or 2^CNT_W when wrap_val==0.
  - rollover_flag is combinational: RUN & cnt_enable & count==W-1.
- If a counter starts at or above W (wrap_val reduced between bursts), the first beat forces it to 0 and asserts rollover_flag.
- start in RUN/DONE is ignored. No queueing.
- Inputs ch_sel, wrap_val and burst_len are don't-care outside the start cycle.
- count_out is driven from the channel indexed by active_ch in every state.
- Non-active channels never change except on clear or rst.
- clear (sync): all counters 0, FSM to IDLE, no done pulse.
  - clear has priority over start and over a beat in the same cycle.
- rst asserted mid-burst: immediate return to reset state. No done pulse.

Optional Feature:
Macro SRAM_CNT_DOWN_EN.
- When defined:
  - Extra input port dir (1 bit), latched on start.
  - dir=1 makes the burst decrement: 0 -> W-1 on a wrap, with rollover_flag high in that beat cycle.
  - A start value >= W loads W-1.
- When undefined: the dir port is absent and the block counts up only, exactly as above.

Decomposition:
- Package sram_cnt_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sram_cnt_state_t
  - default width constants
  - a wrap-compute function shared by the FSM and the sub-module
- Sub-module sram_ch_counter is a single-channel wrap counter.
  - Ports: clk, rst, clear, step, [dir], wrap_val, count, wrap.
  - The top instantiates it NUM_CH times in a generate loop. Only the channel matching active_ch receives step.

Test Plan:
- Reset: rst pulse mid-RUN -> next cycle busy=0, done=0, all ch_count=0, FSM IDLE, no done pulse later.
- Basic burst: ch_sel=2, wrap_val=0, burst_len=5, cnt_enable=1 -> count_out 0,1,2,3,4 over 5 cycles; done pulse in cycle 6; ch2=5; others 0.
- Wrap/resume: ch1 with wrap_val=10, burst_len=8, then a second burst_len=4 -> second burst yields 8,9,0,1; rollover_flag on the beat at 9; ch1 ends at 2.
- Stall, ignored start and zero length:
  - cnt_enable toggled 1,0,0,1,... in a 3-beat burst -> count holds during stalls; done follows the 3rd enabled beat.
  - start during RUN -> ignored.
  - burst_len=0 -> done after 1 cycle; counters unchanged.
- Clear priority: clear=1 and start=1 in the same cycle while ch3=40 -> all counters 0, stay IDLE, no busy, no done.
- SRAM_CNT_DOWN_EN build: ch0 at 2, wrap_val=4, dir=1, burst_len=4 -> count_out 2,1,0,3; rollover_flag on the beat at 0; ch0 ends at 2.

Source files
------------

// File: rtl/sram_cnt_pkg.sv
// sram_cnt_pkg
// Shared types, default widths and wrap arithmetic for the multi-channel
// SRAM burst counter.
// Contents:
//   sram_cnt_state_t : burst FSM state encoding (IDLE, RUN, DONE)
//   DEF_CNT_W        : default counter / address width
//   DEF_NUM_CH       : default number of channel counters
//   wrap_hit()       : true when the next step of a counter wraps
//   wrap_step()      : next counter value for one step
// Optional feature macro: SRAM_CNT_DOWN_EN (down counting via the dir argument)
// The helpers work on 32-bit values, so counter widths must stay below 32.
package sram_cnt_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sram_cnt_state_t;

  localparam int DEF_CNT_W  = 7;
  localparam int DEF_NUM_CH = 4;

  // Effective modulus: a wrap value of 0 selects the full 2^cnt_w range.
  function automatic logic [31:0] wrap_mod(input logic [31:0] wrap_val,
                                           input int unsigned cnt_w);
    return (wrap_val == 32'd0) ? (32'd1 << cnt_w) : wrap_val;
  endfunction

  // A counter sitting at or above the modulus (wrap point lowered between
  // bursts) is treated as wrapping, so its first step lands back in range.
  function automatic logic wrap_hit(input logic [31:0] count,
                                    input logic [31:0] wrap_val,
                                    input int unsigned cnt_w,
                                    input logic        dir);
    logic [31:0] w;
    w = wrap_mod(wrap_val, cnt_w);
    if (dir)
      return (count == 32'd0) || (count >= w);
    else
      return (count >= w - 32'd1);
  endfunction

  function automatic logic [31:0] wrap_step(input logic [31:0] count,
                                            input logic [31:0] wrap_val,
                                            input int unsigned cnt_w,
                                            input logic        dir);
    logic [31:0] w;
    w = wrap_mod(wrap_val, cnt_w);
    if (wrap_hit(count, wrap_val, cnt_w, dir))
      return dir ? (w - 32'd1) : 32'd0;
    else
      return dir ? (count - 32'd1) : (count + 32'd1);
  endfunction

endpackage

// File: rtl/sram_ch_counter.sv
// sram_ch_counter
// One channel of the SRAM burst counter: a wrap counter with a programmable
// wrap point that advances only when stepped.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset, count -> 0
//   clear    : synchronous clear, count -> 0 (beats step)
//   step     : advance the counter by one at the next edge
//   dir      : (SRAM_CNT_DOWN_EN only) 1 = count down
//   wrap_val : wrap point, 0 = full 2^CNT_W range
//   count    : current counter value
//   wrap     : the next step from the current value wraps
// Optional feature macro: SRAM_CNT_DOWN_EN
module sram_ch_counter
  import sram_cnt_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
`ifdef SRAM_CNT_DOWN_EN
  input  logic             dir,
`endif
  input  logic [CNT_W-1:0] wrap_val,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  logic dir_i;

`ifdef SRAM_CNT_DOWN_EN
  assign dir_i = dir;
`else
  assign dir_i = 1'b0;
`endif

  // Wrap indication is independent of step so the parent can qualify it
  // with its own beat condition.
  assign wrap = wrap_hit(32'(count), 32'(wrap_val), CNT_W, dir_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (step)
      count <= CNT_W'(wrap_step(32'(count), 32'(wrap_val), CNT_W, dir_i));
  end

endmodule

// File: rtl/sram_burst_counter.sv
// sram_burst_counter
// NUM_CH independent SRAM address wrap counters. A burst FSM steps one
// selected channel for a requested number of beats; every channel keeps its
// pointer between bursts so each buffer resumes where it stopped.
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   clear         : synchronous clear of all counters, aborts any burst
//   start         : burst request, only looked at in IDLE
//   ch_sel        : channel to step, latched on an accepted start
//   wrap_val      : wrap point (0 = full range), latched on start
//   burst_len     : number of beats, latched on start (0 = immediate done)
//   dir           : (SRAM_CNT_DOWN_EN only) 1 = count down, latched on start
//   cnt_enable    : beat qualifier while running, low stalls the burst
//   busy          : high in RUN and DONE
//   done          : one-cycle pulse at the end of a burst
//   rollover_flag : the active channel wraps on this beat
//   count_out     : current value of the latched channel
//   active_ch     : latched channel index
//   ch_count      : all counters, channel i at [i*CNT_W +: CNT_W]
// Optional feature macro: SRAM_CNT_DOWN_EN
module sram_burst_counter
  import sram_cnt_pkg::*;
#(
  parameter  int CNT_W  = DEF_CNT_W,
  parameter  int NUM_CH = DEF_NUM_CH,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    start,
  input  logic [CH_W-1:0]         ch_sel,
  input  logic [CNT_W-1:0]        wrap_val,
  input  logic [CNT_W-1:0]        burst_len,
`ifdef SRAM_CNT_DOWN_EN
  input  logic                    dir,
`endif
  input  logic                    cnt_enable,
  output logic                    busy,
  output logic                    done,
  output logic                    rollover_flag,
  output logic [CNT_W-1:0]        count_out,
  output logic [CH_W-1:0]         active_ch,
  output logic [NUM_CH*CNT_W-1:0] ch_count
);

  sram_cnt_state_t  state, next_state;
  logic [CH_W-1:0]  ch_q;
  logic [CNT_W-1:0] wrap_q;
  logic [CNT_W-1:0] beats_left;
  logic             dir_q;
  logic             beat;
  logic             accept;

  logic [CNT_W-1:0] cnt_arr  [NUM_CH];
  logic [NUM_CH-1:0] wrap_arr;

  assign accept = (state == IDLE) && start && !clear;

  // A beat never lands in the same cycle as a clear; clear wins.
  assign beat = (state == RUN) && cnt_enable && !clear;

  // Next-state and status outputs.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          next_state = (burst_len == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_enable && (beats_left == CNT_W'(1)))
          next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (clear)
      next_state = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Burst context: channel, wrap point, direction and remaining beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q       <= '0;
      wrap_q     <= '0;
      beats_left <= '0;
    end else if (clear) begin
      beats_left <= '0;
    end else if (accept) begin
      ch_q       <= ch_sel;
      wrap_q     <= wrap_val;
      beats_left <= burst_len;
    end else if (beat) begin
      beats_left <= beats_left - CNT_W'(1);
    end
  end

`ifdef SRAM_CNT_DOWN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dir_q <= 1'b0;
    else if (accept)
      dir_q <= dir;
  end
`else
  assign dir_q = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sram_ch_counter #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .step    (beat && (ch_q == CH_W'(i))),
`ifdef SRAM_CNT_DOWN_EN
      .dir     (dir_q),
`endif
      .wrap_val(wrap_q),
      .count   (cnt_arr[i]),
      .wrap    (wrap_arr[i])
    );
    assign ch_count[i*CNT_W +: CNT_W] = cnt_arr[i];
  end

  assign active_ch     = ch_q;
  assign count_out     = cnt_arr[ch_q];
  assign rollover_flag = (state == RUN) && cnt_enable && wrap_arr[ch_q];

endmodule

// File: tb/tb_sram_burst_counter.sv
// tb_sram_burst_counter
// Scoreboard bench for sram_burst_counter. Each burst pushes its expected
// beat addresses, rollover flags and done pulse into a queue; a monitor pops
// and compares them as the DUT produces beats. Direct checks cover reset,
// clear priority, reset mid-burst and final counter values.
// Optional feature macro: SRAM_CNT_DOWN_EN (adds the dir port and a down test)
module tb_sram_burst_counter;

  localparam int CNT_W  = 7;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic                    clk;
  logic                    rst;
  logic                    clear;
  logic                    start;
  logic [CH_W-1:0]         ch_sel;
  logic [CNT_W-1:0]        wrap_val;
  logic [CNT_W-1:0]        burst_len;
  logic                    dir;
  logic                    cnt_enable;
  logic                    busy;
  logic                    done;
  logic                    rollover_flag;
  logic [CNT_W-1:0]        count_out;
  logic [CH_W-1:0]         active_ch;
  logic [NUM_CH*CNT_W-1:0] ch_count;

  typedef struct {
    int count;
    bit roll;
    bit is_done;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_item;
  bit   sb_enable;
  int   model_cnt[NUM_CH];
  int   tests_run;
  int   tests_failed;

  sram_burst_counter #(
    .CNT_W (CNT_W),
    .NUM_CH(NUM_CH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .start        (start),
    .ch_sel       (ch_sel),
    .wrap_val     (wrap_val),
    .burst_len    (burst_len),
`ifdef SRAM_CNT_DOWN_EN
    .dir          (dir),
`endif
    .cnt_enable   (cnt_enable),
    .busy         (busy),
    .done         (done),
    .rollover_flag(rollover_flag),
    .count_out    (count_out),
    .active_ch    (active_ch),
    .ch_count     (ch_count)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run can never hang
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference step: W is the modulus, counters at or past the wrap edge wrap
  function automatic int modelMod(input int w);
    return (w == 0) ? (1 << CNT_W) : w;
  endfunction

  task automatic checkCounters(input string tag);
    for (int i = 0; i < NUM_CH; i++)
      checkOutput($sformatf("%s_ch%0d", tag, i), 32'(ch_count[i*CNT_W +: CNT_W]), model_cnt[i]);
  endtask

  // Monitor: every enabled RUN beat and every done cycle consumes one entry
  always @(negedge clk) begin
    if (sb_enable && !rst && busy && (done || cnt_enable)) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_unexpected_output", 1, 0);
      end else begin
        mon_item = sb_q.pop_front();
        checkOutput("sb_done", 32'(done), 32'(mon_item.is_done));
        checkOutput("sb_count", 32'(count_out), mon_item.count);
        checkOutput("sb_rollover", 32'(rollover_flag),
                    mon_item.is_done ? 0 : 32'(mon_item.roll));
      end
    end
  end

  // Drive one burst, pushing expectations first. pat gives cnt_enable per
  // RUN cycle (LSB first); poke raises a second start during RUN.
  task automatic applyStimulus(input int ch, input int wrap, input int len,
                               input bit dn, input logic [15:0] pat, input bit poke);
    exp_t e;
    int   c;
    int   w;
    int   cyc;
    bit   fin;
    w = modelMod(wrap);
    c = model_cnt[ch];
    for (int k = 0; k < len; k++) begin
      e.count   = c;
      e.is_done = 1'b0;
      if (dn) begin
        e.roll = (c == 0) || (c >= w);
        c = e.roll ? (w - 1) : (c - 1);
      end else begin
        e.roll = (c >= w - 1);
        c = e.roll ? 0 : (c + 1);
      end
      sb_q.push_back(e);
    end
    model_cnt[ch] = c;
    e.count   = c;
    e.roll    = 1'b0;
    e.is_done = 1'b1;
    sb_q.push_back(e);

    start     = 1'b1;
    ch_sel    = 2'(ch);
    wrap_val  = 7'(wrap);
    burst_len = 7'(len);
    dir       = dn;
    @(posedge clk);
    #1;
    start     = 1'b0;
    ch_sel    = 2'($urandom);
    wrap_val  = 7'($urandom);
    burst_len = 7'($urandom);
    dir       = 1'($urandom);
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 64) begin
      cnt_enable = pat[cyc[3:0]];
      if (poke && cyc == 1) begin
        start     = 1'b1;
        ch_sel    = 2'((ch + 1) % NUM_CH);
        burst_len = 7'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!busy) fin = 1'b1;
    end
    start      = 1'b0;
    cnt_enable = 1'b0;
    checkOutput("burst_finished", 32'(fin), 1);
    checkOutput("sb_drain", sb_q.size(), 0);
    sb_q.delete();
    checkCounters("after_burst");
  endtask

  initial begin
    bit saw_done;
    tests_run    = 0;
    tests_failed = 0;
    sb_enable    = 1'b0;
    rst          = 1'b1;
    clear        = 1'b0;
    start        = 1'b0;
    ch_sel       = '0;
    wrap_val     = '0;
    burst_len    = '0;
    dir          = 1'b0;
    cnt_enable   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) model_cnt[i] = 0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_rollover", 32'(rollover_flag), 0);
    checkOutput("reset_count_out", 32'(count_out), 0);
    checkOutput("reset_active_ch", 32'(active_ch), 0);
    checkCounters("reset");
    sb_enable = 1'b1;

    // Basic burst on channel 2: 0..4, ends at 5
    applyStimulus(2, 0, 5, 1'b0, 16'hFFFF, 1'b0);
    checkOutput("basic_ch2_final", 32'(ch_count[2*CNT_W +: CNT_W]), 5);

    // Wrap and resume on channel 1 (wrap 10): 0..7 then 8,9,0,1
    applyStimulus(1, 10, 8, 1'b0, 16'hFFFF, 1'b0);
    applyStimulus(1, 10, 4, 1'b0, 16'hFFFF, 1'b0);
    checkOutput("wrap_ch1_final", 32'(ch_count[1*CNT_W +: CNT_W]), 2);

    // Stalled 3-beat burst on channel 0, enable 1,0,0,1,0,1,...
    applyStimulus(0, 0, 3, 1'b0, 16'hFFE9, 1'b0);

    // Start raised during RUN must be ignored
    applyStimulus(3, 0, 4, 1'b0, 16'hFFFF, 1'b1);

    // Zero-length burst: done right away, counters unchanged
    applyStimulus(0, 0, 0, 1'b0, 16'hFFFF, 1'b0);

    // Wrap point lowered below the current value: first beat forces 0
    applyStimulus(2, 3, 2, 1'b0, 16'hFFFF, 1'b0);

    // Bring channel 3 to 40, then clear and start together
    applyStimulus(3, 0, 36, 1'b0, 16'hFFFF, 1'b0);
    checkOutput("pre_clear_ch3", 32'(ch_count[3*CNT_W +: CNT_W]), 40);
    start     = 1'b1;
    clear     = 1'b1;
    ch_sel    = 2'd3;
    burst_len = 7'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < NUM_CH; i++) model_cnt[i] = 0;
    checkOutput("clear_busy", 32'(busy), 0);
    checkOutput("clear_done", 32'(done), 0);
    checkCounters("clear");
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | done | busy;
    end
    checkOutput("clear_stays_idle", 32'(saw_done), 0);

    // Reset in the middle of a burst
    sb_enable  = 1'b0;
    start      = 1'b1;
    ch_sel     = 2'd2;
    wrap_val   = 7'd0;
    burst_len  = 7'd5;
    @(posedge clk);
    #1;
    start      = 1'b0;
    cnt_enable = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrun_busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("midrun_rst_busy", 32'(busy), 0);
    checkOutput("midrun_rst_done", 32'(done), 0);
    checkCounters("midrun_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | done | busy;
    end
    cnt_enable = 1'b0;
    checkOutput("midrun_no_done_later", 32'(saw_done), 0);
    sb_enable = 1'b1;

`ifdef SRAM_CNT_DOWN_EN
    // Down count on channel 0 from 2 with wrap 4: 2,1,0,3 -> ends at 2
    applyStimulus(0, 0, 2, 1'b0, 16'hFFFF, 1'b0);
    applyStimulus(0, 4, 4, 1'b1, 16'hFFFF, 1'b0);
    checkOutput("down_ch0_final", 32'(ch_count[0 +: CNT_W]), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
